// File: rtl/segment_sampler.sv
// Proposal generator for a stochastic local-search solver: draws a new value for one
// variable inside [from, to], either uniformly (rejection sampling) or exponentially biased.
//
// state | meaning
// IDLE  | ready for a request; out_ready=1
// CHECK | validate type and bounds, compute span
// DRAW  | one LFSR word consumed per cycle; uniform may repeat on rejection
// DONE  | result held on outputs until in_ready
module segment_sampler #(
    parameter int WIDTH       = 8,
    parameter int NUM_VARS    = 4,
    parameter int INDEX_WIDTH = 2,
    parameter int MAX_TRIES   = 8
) (
    input  logic                          in_clock,
    input  logic                          in_reset,
    input  logic [15:0]                   in_seed,
    input  logic                          in_valid,
    output logic                          out_ready,
    input  logic [INDEX_WIDTH-1:0]        in_var_index,
    input  logic signed [WIDTH-1:0]       in_from,
    input  logic signed [WIDTH-1:0]       in_to,
    input  logic [1:0]                    in_type,
    input  logic [WIDTH-1:0]              in_weight,
    output logic                          out_valid,
    input  logic                          in_ready,
    output logic signed [WIDTH-1:0]       out_proposed_value,
    output logic [INDEX_WIDTH-1:0]        out_var_index,
    output logic                          out_error,
    output logic                          out_fallback
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [1:0] TYPE_UNIFORM = 2'd3;
    localparam logic [1:0] TYPE_EXPUP   = 2'd2;
    localparam logic [1:0] TYPE_INVALID = 2'd0;

    if (NUM_VARS > (1 << INDEX_WIDTH)) begin : g_bad_index_width
        $error("INDEX_WIDTH too small for NUM_VARS");
    end

    typedef enum logic [1:0] {IDLE, CHECK, DRAW, DONE} state_t;

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
    logic signed [WIDTH-1:0]  from_q, from_d;
    logic signed [WIDTH-1:0]  to_q, to_d;
    logic [1:0]               type_q, type_d;
    logic [WIDTH-1:0]         weight_q, weight_d;
    logic [TW-1:0]            tries_q, tries_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic signed [WIDTH-1:0]  val_q, val_d;
    logic                     err_q, err_d;
    logic                     fb_q, fb_d;

    logic signed [WIDTH:0]    from_x, to_x, span;
    logic [WIDTH-1:0]         span_u, mask, lfsr_w, r;
    logic                     r_ok;
    logic signed [WIDTH:0]    uni_x, up_x, down_x;
    logic [4:0]               ones;
    logic                     stop;
    logic [3:0]               k;
    logic [WIDTH+3:0]         prod;
    logic [WIDTH-1:0]         offset;
    logic [15:0]              lfsr_next;

    // Datapath: all bound arithmetic is done one bit wider so nothing wraps.
    always_comb begin
        from_x = {from_q[WIDTH-1], from_q};
        to_x   = {to_q[WIDTH-1], to_q};
        span   = to_x - from_x;
        span_u = span[WIDTH-1:0];

        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask = mask | (span_u >> i);
        end
        for (int i = 0; i < WIDTH; i++) begin
            lfsr_w[i] = lfsr_q[i % 16];
        end
        r     = lfsr_w & mask;
        r_ok  = (r <= span_u);
        uni_x = from_x + {1'b0, r};

        ones = '0;
        stop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!lfsr_q[i]) begin
                stop = 1'b1;
            end else if (!stop) begin
                ones = ones + 5'd1;
            end
        end
        k      = (ones > 5'd15) ? 4'd15 : ones[3:0];
        prod   = (WIDTH+4)'(k) * (WIDTH+4)'(weight_q);
        offset = (prod > (WIDTH+4)'(span_u)) ? span_u : prod[WIDTH-1:0];
        up_x   = to_x - {1'b0, offset};
        down_x = from_x + {1'b0, offset};

        lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        from_d   = from_q;
        to_d     = to_q;
        type_d   = type_q;
        weight_d = weight_q;
        tries_d  = tries_q;
        lfsr_d   = lfsr_q;
        val_d    = val_q;
        err_d    = err_q;
        fb_d     = fb_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    idx_d    = in_var_index;
                    from_d   = in_from;
                    to_d     = in_to;
                    type_d   = in_type;
                    weight_d = in_weight;
                    tries_d  = '0;
                    err_d    = 1'b0;
                    fb_d     = 1'b0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (type_q == TYPE_INVALID || span[WIDTH]) begin
                    val_d   = from_q;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                lfsr_d = lfsr_next;
                if (type_q == TYPE_UNIFORM) begin
                    if (r_ok) begin
                        val_d   = uni_x[WIDTH-1:0];
                        state_d = DONE;
                    end else if (tries_q == TW'(MAX_TRIES - 1)) begin
                        val_d   = from_q;
                        fb_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        tries_d = tries_q + TW'(1);
                    end
                end else begin
                    val_d   = (type_q == TYPE_EXPUP) ? up_x[WIDTH-1:0] : down_x[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (in_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            from_q   <= '0;
            to_q     <= '0;
            type_q   <= '0;
            weight_q <= '0;
            tries_q  <= '0;
            lfsr_q   <= (in_seed == 16'h0000) ? 16'h0001 : in_seed;
            val_q    <= '0;
            err_q    <= 1'b0;
            fb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            from_q   <= from_d;
            to_q     <= to_d;
            type_q   <= type_d;
            weight_q <= weight_d;
            tries_q  <= tries_d;
            lfsr_q   <= lfsr_d;
            val_q    <= val_d;
            err_q    <= err_d;
            fb_q     <= fb_d;
        end
    end

    assign out_ready          = (state_q == IDLE);
    assign out_valid          = (state_q == DONE);
    assign out_proposed_value = val_q;
    assign out_var_index      = idx_q;
    assign out_error          = err_q;
    assign out_fallback       = fb_q;

endmodule
